// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - main control FSM for the multi-cycle RISC-V core
// Moore state sequencer plus combinational ALU and immediate-format decoders.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Op,
  input  logic [2:0] Funct3,
  input  logic       Funct7b5,
  input  logic       Zero,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       AdrSrc,
  output logic [2:0] ALUControl,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       Illegal,
  output logic [3:0] State
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWR    = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  logic [3:0] state_q, state_d;
  logic [3:0] out_state;
  logic [1:0] alu_op;
  logic       pc_update, branch;
  logic       ir_write, reg_write, mem_write;
  logic       op_legal;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  assign op_legal = (Op == OP_LW) || (Op == OP_SW) || (Op == OP_R) ||
                    (Op == OP_I)  || (Op == OP_BEQ);

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:   state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (Op == OP_LW)      state_d = S_MEMREAD;
        else if (Op == OP_SW) state_d = S_MEMWR;
        else                  state_d = S_FETCH;
      end
      S_MEMREAD: state_d = S_MEMWB;
      S_EXECR:   state_d = S_ALUWB;
      S_EXECI:   state_d = S_ALUWB;
      default:   state_d = S_FETCH;
    endcase
  end

  // Selects show Fetch values while rst is high; enables are gated below.
  assign out_state = rst ? S_FETCH : state_q;

  always_comb begin
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    AdrSrc    = 1'b0;
    alu_op    = 2'b00;
    pc_update = 1'b0;
    branch    = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    case (out_state)
      S_FETCH: begin
        ir_write  = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pc_update = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        branch  = 1'b1;
      end
      default: ;
    endcase
    IRWrite  = ir_write  & ~rst;
    PCWrite  = (pc_update | (branch & Zero)) & ~rst;
    RegWrite = reg_write & ~rst;
    MemWrite = mem_write & ~rst;
    Illegal  = ~rst & (state_q == S_DECODE) & ~op_legal;
    State    = state_q;
  end

  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (Funct3)
          3'b000:  ALUControl = (Op[5] & Funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    ImmSrc = 2'b00;
    if (Op == OP_SW)       ImmSrc = 2'b01;
    else if (Op == OP_BEQ) ImmSrc = 2'b10;
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] Op;
  logic [2:0] Funct3;
  logic       Funct7b5;
  logic       Zero;
  logic [1:0] ImmSrc, ALUSrcA, ALUSrcB, ResultSrc;
  logic       AdrSrc;
  logic [2:0] ALUControl;
  logic       IRWrite, PCWrite, RegWrite, MemWrite, Illegal;
  logic [3:0] State;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct3(Funct3), .Funct7b5(Funct7b5), .Zero(Zero),
    .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .AdrSrc(AdrSrc), .ALUControl(ALUControl), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .Illegal(Illegal), .State(State)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  typedef struct packed {
    logic [3:0] state;
    logic [4:0] en;
    logic [6:0] sel;
    logic [2:0] alu;
    logic [1:0] imm;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, want);
    end
  endtask

  // Reference outputs straight from the per-state control table.
  function automatic exp_t model(input logic [3:0] st, input logic r, input logic [6:0] op,
                                 input logic [2:0] f3, input logic f7, input logic z);
    exp_t e;
    logic [3:0] s;
    logic [1:0] a, b, res, aop;
    logic adr, irw, pcu, br, rw, mw, ill;
    s = r ? 4'd0 : st;
    a = 2'b00; b = 2'b00; res = 2'b00; aop = 2'b00;
    adr = 0; irw = 0; pcu = 0; br = 0; rw = 0; mw = 0; ill = 0;
    case (s)
      4'd0: begin irw = 1; b = 2'b10; res = 2'b10; pcu = 1; end
      4'd1: begin
        a = 2'b01; b = 2'b01;
        ill = !(op == LW || op == SW || op == RT || op == IT || op == BEQ);
      end
      4'd2: begin a = 2'b10; b = 2'b01; end
      4'd3: adr = 1;
      4'd4: begin res = 2'b01; rw = 1; end
      4'd5: begin adr = 1; mw = 1; end
      4'd6: begin a = 2'b10; aop = 2'b10; end
      4'd7: begin a = 2'b10; b = 2'b01; aop = 2'b10; end
      4'd8: rw = 1;
      4'd9: begin a = 2'b10; aop = 2'b01; br = 1; end
      default: ;
    endcase
    e.state = st;
    e.en    = r ? 5'b0 : {irw, pcu | (br & z), rw, mw, ill};
    e.sel   = {a, b, res, adr};
    if (aop == 2'b01) e.alu = 3'b001;
    else if (aop == 2'b10) begin
      if (f3 == 3'b000)      e.alu = (op[5] && f7) ? 3'b001 : 3'b000;
      else if (f3 == 3'b010) e.alu = 3'b101;
      else if (f3 == 3'b110) e.alu = 3'b011;
      else if (f3 == 3'b111) e.alu = 3'b010;
      else                   e.alu = 3'b000;
    end else e.alu = 3'b000;
    e.imm = (op == SW) ? 2'b01 : (op == BEQ) ? 2'b10 : 2'b00;
    return e;
  endfunction

  // Called at a negedge: push expectation, sample after settling, advance one cycle.
  task automatic step(input logic [3:0] st);
    exp_t e;
    exp_q.push_back(model(st, rst, Op, Funct3, Funct7b5, Zero));
    #1;
    e = exp_q.pop_front();
    check_eq("state", {28'd0, State}, {28'd0, e.state});
    check_eq("enables", {27'd0, IRWrite, PCWrite, RegWrite, MemWrite, Illegal}, {27'd0, e.en});
    check_eq("selects", {25'd0, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc}, {25'd0, e.sel});
    check_eq("alu_control", {29'd0, ALUControl}, {29'd0, e.alu});
    check_eq("imm_src", {30'd0, ImmSrc}, {30'd0, e.imm});
    @(negedge clk);
    cyc++;
  endtask

  // seq holds the expected state codes as nibbles, first state in the most significant used nibble.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic z, input logic [19:0] seq, input int n);
    Op = op; Funct3 = f3; Funct7b5 = f7; Zero = z;
    for (int i = 0; i < n; i++) step(seq[4*(n-1-i) +: 4]);
  endtask

  initial begin
    rst = 1'b1; Op = SW; Funct3 = 3'b000; Funct7b5 = 1'b0; Zero = 1'b0;
    @(negedge clk);
    step(4'd0);
    step(4'd0);
    rst = 1'b0;

    run_instr(LW,  3'b010, 1'b0, 1'b1, 20'h01234, 5);
    run_instr(SW,  3'b010, 1'b0, 1'b1, 20'h00125, 4);
    run_instr(BEQ, 3'b000, 1'b0, 1'b1, 20'h00019, 3);
    run_instr(BEQ, 3'b000, 1'b0, 1'b0, 20'h00019, 3);
    run_instr(RT,  3'b000, 1'b1, 1'b1, 20'h00168, 4);
    run_instr(RT,  3'b000, 1'b0, 1'b0, 20'h00168, 4);
    run_instr(IT,  3'b000, 1'b1, 1'b0, 20'h00178, 4);
    run_instr(RT,  3'b010, 1'b0, 1'b0, 20'h00168, 4);
    run_instr(IT,  3'b110, 1'b0, 1'b0, 20'h00178, 4);
    run_instr(RT,  3'b111, 1'b0, 1'b0, 20'h00168, 4);
    run_instr(IT,  3'b001, 1'b0, 1'b1, 20'h00178, 4);
    run_instr(BAD, 3'b000, 1'b0, 1'b1, 20'h00001, 2);

    // Abort a store in MemWr with reset.
    run_instr(SW, 3'b000, 1'b0, 1'b0, 20'h00012, 3);
    rst = 1'b1;
    step(4'd5);
    rst = 1'b0;
    run_instr(LW, 3'b000, 1'b0, 1'b0, 20'h01234, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
